hawk_cline_swap_buf: RTL and testbench

HAWK_CLINE_SWAP_BUF -- requirements
Module: hawk_cline_swap_buf

---
 rtl/hacd_pkg.sv | 12 +
 rtl/hawk_sync_fifo.sv | 63 ++++++
 rtl/hawk_cline_swap_buf.sv | 106 ++++++++++
 tb/tb_hawk_cline_swap_buf.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hacd_pkg.sv
// Shared definitions for the hawk cacheline swap buffer: swap-mode encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hacd_pkg;

    // Byte-swap modes, sampled with each line at push time
    localparam logic [1:0] HAWK_SWAP_NONE    = 2'd0;
    localparam logic [1:0] HAWK_SWAP_SWAP8B  = 2'd1;
    localparam logic [1:0] HAWK_SWAP_REVLINE = 2'd2;
    localparam logic [1:0] HAWK_SWAP_SWAP4B  = 2'd3;

endpackage

// File: rtl/hawk_sync_fifo.sv
// Generic synchronous FIFO with unreset storage and a fall-through read port.
// Latency: an entry written at edge N is on rdata_o after edge N.
// Backpressure: the caller must gate push_i with !full_o and pop_i with !empty_o.
module hawk_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    // Entry storage needs no reset; only written on an accepted push
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; occupancy tracks push minus pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_i) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CNT_ONE;
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    assign rdata_o = mem[rd_ptr];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/hawk_cline_swap_buf.sv
// Cacheline buffer applying a per-line byte-swap transform at push, with zero detect.
// Latency: 1 cycle minimum (line pushed at edge N is visible after edge N); no in->out comb path.
// Backpressure: valid/ready both sides; in_ready_o drops when full, no pass-through when full.
module hawk_cline_swap_buf
    import hacd_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [1:0]             mode_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_W-1:0]      in_data_i,
    input  logic [DATA_W/8-1:0]    in_strb_i,
    input  logic                   in_last_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_W-1:0]      out_data_o,
    output logic [DATA_W/8-1:0]    out_strb_o,
    output logic                   out_last_o,
    output logic                   out_zero_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [31:0]            lines_o
);

    localparam int NB = DATA_W / 8;
    localparam int EW = DATA_W + NB + 2;

    logic [DATA_W-1:0] xf_data;
    logic [NB-1:0]     xf_strb;
    logic              xf_zero;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [EW-1:0]     rd_entry;
    logic [DATA_W-1:0] rd_data;
    logic [NB-1:0]     rd_strb;
    logic              rd_last;
    logic              rd_zero;
    logic [31:0]       lines_q;

    // Each output byte picks its source byte; the strobe bit follows the same mapping
    for (genvar i = 0; i < NB; i++) begin : g_byte
        localparam int SRC8 = i ^ 7;
        localparam int SRC4 = i ^ 3;
        localparam int SRCR = NB - 1 - i;

        assign xf_data[i*8 +: 8] =
            (mode_i == HAWK_SWAP_SWAP8B)  ? in_data_i[SRC8*8 +: 8] :
            (mode_i == HAWK_SWAP_REVLINE) ? in_data_i[SRCR*8 +: 8] :
            (mode_i == HAWK_SWAP_SWAP4B)  ? in_data_i[SRC4*8 +: 8] :
                                            in_data_i[i*8 +: 8];

        assign xf_strb[i] =
            (mode_i == HAWK_SWAP_SWAP8B)  ? in_strb_i[SRC8] :
            (mode_i == HAWK_SWAP_REVLINE) ? in_strb_i[SRCR] :
            (mode_i == HAWK_SWAP_SWAP4B)  ? in_strb_i[SRC4] :
                                            in_strb_i[i];
    end

    // Zero flag looks at data only; strobes are deliberately ignored
    assign xf_zero = ~|xf_data;

    assign in_ready_o  = ~full;
    assign out_valid_o = ~empty;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    hawk_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i ({xf_data, xf_strb, in_last_i, xf_zero}),
        .pop_i   (pop),
        .rdata_o (rd_entry),
        .count_o (count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    assign {rd_data, rd_strb, rd_last, rd_zero} = rd_entry;

    // Outputs are forced to zero while empty so unwritten storage never leaks out
    assign out_data_o = out_valid_o ? rd_data : '0;
    assign out_strb_o = out_valid_o ? rd_strb : '0;
    assign out_last_o = out_valid_o & rd_last;
    assign out_zero_o = out_valid_o & rd_zero;

    // Count popped lines; the 32-bit counter wraps to zero on overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lines_q <= '0;
        end else if (pop) begin
            lines_q <= lines_q + 32'd1;
        end
    end

    assign lines_o = lines_q;

endmodule

// File: tb/tb_hawk_cline_swap_buf.sv
// Self-checking bench for hawk_cline_swap_buf (DATA_W=512, DEPTH=4).
// Expected lines are modelled at push time and queued; compared as the DUT pops them.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_hawk_cline_swap_buf;

    typedef struct packed {
        logic [511:0] d;
        logic [63:0]  s;
        logic         l;
        logic         z;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [1:0]   mode_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [511:0] in_data_i;
    logic [63:0]  in_strb_i;
    logic         in_last_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [511:0] out_data_o;
    logic [63:0]  out_strb_o;
    logic         out_last_o;
    logic         out_zero_o;
    logic [2:0]   count_o;
    logic [31:0]  lines_o;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_lines = 32'd0;

    hawk_cline_swap_buf #(.DATA_W(512), .DEPTH(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .mode_i      (mode_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_strb_i   (in_strb_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_strb_o  (out_strb_o),
        .out_last_o  (out_last_o),
        .out_zero_o  (out_zero_o),
        .count_o     (count_o),
        .lines_o     (lines_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference transform, written word-by-word rather than as an index XOR
    function automatic exp_t model(input logic [1:0] m, input logic [511:0] d,
                                   input logic [63:0] s, input logic l);
        exp_t e;
        int   src;
        e = '0;
        for (int k = 0; k < 64; k++) begin
            case (m)
                2'd1:    src = (k / 8) * 8 + 7 - (k % 8);
                2'd2:    src = 63 - k;
                2'd3:    src = (k / 4) * 4 + 3 - (k % 4);
                default: src = k;
            endcase
            e.d[k*8 +: 8] = d[src*8 +: 8];
            e.s[k]        = s[src];
        end
        e.l = l;
        e.z = (e.d == '0);
        return e;
    endfunction

    function automatic logic [511:0] rnd_line();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] rnd_strb();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r;
    endfunction

    // Offer one line for a single cycle; queue its expectation if it is accepted
    task automatic push_line(input logic [1:0] m, input logic [511:0] d,
                             input logic [63:0] s, input logic l);
        mode_i     = m;
        in_data_i  = d;
        in_strb_i  = s;
        in_last_i  = l;
        in_valid_i = 1'b1;
        if (in_ready_o) sb.push_back(model(m, d, s, l));
        @(posedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #3;
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid_o); end
        n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", in_ready_o); end
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count_o); end
        n_cmp++; if (lines_o !== 32'd0) begin n_err++; $display("FAIL rst_lines: got %h want 0", lines_o); end
        n_cmp++; if ({out_data_o, out_strb_o, out_last_o, out_zero_o} !== '0) begin
            n_err++; $display("FAIL rst_outs: got d=%h s=%h l=%b z=%b want all 0", out_data_o, out_strb_o, out_last_o, out_zero_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_transforms();
        logic [511:0] d;
        exp_t         e;
        out_ready_i = 1'b0;
        d = '0;
        d[63:0] = 64'h0102030405060708;
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL pre_push_valid: got %b want 0", out_valid_o); end
        push_line(2'd1, d, 64'h1, 1'b0);
        n_cmp++; if (out_valid_o !== 1'b1) begin n_err++; $display("FAIL latency_valid: got %b want 1", out_valid_o); end
        n_cmp++; if (out_data_o[63:0] !== 64'h0807060504030201) begin n_err++; $display("FAIL swap8b_word0: got %h want 0807060504030201", out_data_o[63:0]); end
        n_cmp++; if (out_strb_o !== 64'h80) begin n_err++; $display("FAIL swap8b_strb: got %h want 80", out_strb_o); end
        d = '0;
        d[7:0] = 8'hAA;
        push_line(2'd2, d, 64'h1, 1'b1);
        push_line(2'd3, rnd_line(), rnd_strb(), 1'b0);
        push_line(2'd0, rnd_line(), rnd_strb(), 1'b1);
        out_ready_i = 1'b1;
        for (int c = 0; c < 40 && sb.size() != 0; c++) begin
            if (out_valid_o) begin
                e = sb.pop_front();
                exp_lines++;
                n_cmp++;
                if (out_data_o !== e.d || out_strb_o !== e.s || out_last_o !== e.l || out_zero_o !== e.z) begin
                    n_err++; $display("FAIL xf_line: got d=%h s=%h l=%b z=%b want d=%h s=%h l=%b z=%b", out_data_o, out_strb_o, out_last_o, out_zero_o, e.d, e.s, e.l, e.z);
                end
            end
            @(posedge clk_i);
            @(negedge clk_i);
        end
        out_ready_i = 1'b0;
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL xf_timeout: got %0d lines left want 0", sb.size()); sb.delete(); end
        n_cmp++; if (out_valid_o !== 1'b0 || out_data_o !== '0 || out_strb_o !== '0) begin
            n_err++; $display("FAIL empty_outs: got v=%b d=%h s=%h want all 0", out_valid_o, out_data_o, out_strb_o);
        end
        n_cmp++; if (lines_o !== exp_lines) begin n_err++; $display("FAIL xf_lines: got %0d want %0d", lines_o, exp_lines); end
    endtask

    task automatic test_full_order();
        logic [511:0] d5;
        logic [63:0]  s5;
        bit           pushed5;
        exp_t         e;
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push_line(2'($urandom_range(0, 3)), rnd_line(), rnd_strb(), (i == 3));
        n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", in_ready_o); end
        n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", count_o); end
        d5 = rnd_line();
        s5 = rnd_strb();
        mode_i = 2'd2; in_data_i = d5; in_strb_i = s5; in_last_i = 1'b1;
        in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        pushed5 = 1'b0;
        for (int c = 0; c < 40 && (sb.size() != 0 || !pushed5); c++) begin
            if (in_valid_i && in_ready_o) begin
                sb.push_back(model(2'd2, d5, s5, 1'b1));
                pushed5 = 1'b1;
            end
            if (out_valid_o) begin
                e = sb.pop_front();
                exp_lines++;
                n_cmp++;
                if (out_data_o !== e.d || out_strb_o !== e.s || out_last_o !== e.l || out_zero_o !== e.z) begin
                    n_err++; $display("FAIL full_line: got d=%h s=%h l=%b z=%b want d=%h s=%h l=%b z=%b", out_data_o, out_strb_o, out_last_o, out_zero_o, e.d, e.s, e.l, e.z);
                end
            end
            @(posedge clk_i);
            @(negedge clk_i);
            if (pushed5) in_valid_i = 1'b0;
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        n_cmp++; if (!pushed5 || sb.size() != 0) begin n_err++; $display("FAIL full_timeout: got pushed5=%b left=%0d want 1/0", pushed5, sb.size()); sb.delete(); end
        n_cmp++; if (lines_o !== exp_lines) begin n_err++; $display("FAIL full_lines: got %0d want %0d", lines_o, exp_lines); end
    endtask

    task automatic test_back_to_back();
        logic [511:0] d3;
        logic [63:0]  s3;
        exp_t         e;
        out_ready_i = 1'b0;
        push_line(2'd3, rnd_line(), rnd_strb(), 1'b0);
        push_line(2'd1, rnd_line(), rnd_strb(), 1'b1);
        n_cmp++; if (count_o !== 3'd2) begin n_err++; $display("FAIL b2b_pre_count: got %0d want 2", count_o); end
        d3 = rnd_line();
        s3 = rnd_strb();
        mode_i = 2'd2; in_data_i = d3; in_strb_i = s3; in_last_i = 1'b0;
        in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        if (out_valid_o && sb.size() != 0) begin
            e = sb.pop_front();
            exp_lines++;
            n_cmp++;
            if (out_data_o !== e.d || out_strb_o !== e.s || out_last_o !== e.l || out_zero_o !== e.z) begin
                n_err++; $display("FAIL b2b_head: got d=%h s=%h want d=%h s=%h", out_data_o, out_strb_o, e.d, e.s);
            end
        end
        if (in_ready_o) sb.push_back(model(2'd2, d3, s3, 1'b0));
        @(posedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        n_cmp++; if (count_o !== 3'd2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", count_o); end
        mode_i = 2'd0;
        @(posedge clk_i);
        @(negedge clk_i);
        mode_i = 2'd1;
        out_ready_i = 1'b1;
        for (int c = 0; c < 40 && sb.size() != 0; c++) begin
            if (out_valid_o) begin
                e = sb.pop_front();
                exp_lines++;
                n_cmp++;
                if (out_data_o !== e.d || out_strb_o !== e.s || out_last_o !== e.l || out_zero_o !== e.z) begin
                    n_err++; $display("FAIL b2b_line: got d=%h s=%h l=%b z=%b want d=%h s=%h l=%b z=%b", out_data_o, out_strb_o, out_last_o, out_zero_o, e.d, e.s, e.l, e.z);
                end
            end
            @(posedge clk_i);
            @(negedge clk_i);
        end
        out_ready_i = 1'b0;
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL b2b_timeout: got %0d left want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_zero_wrap();
        exp_t e;
        out_ready_i = 1'b0;
        push_line(2'd0, '0, '1, 1'b1);
        n_cmp++; if (out_zero_o !== 1'b1) begin n_err++; $display("FAIL zero_flag: got %b want 1", out_zero_o); end
        force dut.lines_q = 32'hFFFF_FFFF;
        @(posedge clk_i);
        @(negedge clk_i);
        release dut.lines_q;
        exp_lines = 32'hFFFF_FFFF;
        out_ready_i = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            if (out_valid_o) begin
                e = sb.pop_front();
                exp_lines++;
                n_cmp++;
                if (out_data_o !== e.d || out_strb_o !== e.s || out_last_o !== e.l || out_zero_o !== e.z) begin
                    n_err++; $display("FAIL zero_line: got d=%h s=%h l=%b z=%b want d=%h s=%h l=%b z=%b", out_data_o, out_strb_o, out_last_o, out_zero_o, e.d, e.s, e.l, e.z);
                end
            end
            @(posedge clk_i);
            @(negedge clk_i);
        end
        out_ready_i = 1'b0;
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL zero_timeout: got %0d left want 0", sb.size()); sb.delete(); end
        n_cmp++; if (lines_o !== 32'd0 || exp_lines !== 32'd0) begin n_err++; $display("FAIL lines_wrap: got %h want 00000000", lines_o); end
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) push_line(2'd1, rnd_line(), rnd_strb(), 1'b0);
        n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL arst_pre_count: got %0d want 3", count_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", out_valid_o); end
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", count_o); end
        n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %b want 1", in_ready_o); end
        n_cmp++; if (lines_o !== 32'd0 || out_data_o !== '0) begin n_err++; $display("FAIL arst_clear: got lines=%h d=%h want 0", lines_o, out_data_o); end
        sb.delete();
        exp_lines = 32'd0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        push_line(2'd0, rnd_line(), rnd_strb(), 1'b0);
        n_cmp++; if (count_o !== 3'd1) begin n_err++; $display("FAIL arst_recover: got %0d want 1", count_o); end
        sb.delete();
    endtask

    initial begin
        rst_ni = 1'b0;
        mode_i = 2'd0;
        in_valid_i = 1'b0;
        in_data_i = '0;
        in_strb_i = '0;
        in_last_i = 1'b0;
        out_ready_i = 1'b0;
        test_reset();
        test_transforms();
        test_full_order();
        test_back_to_back();
        test_zero_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
